// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
//
// Shared constants and helpers for the prio_enc priority encoder.
//
// Contents:
//   ACT_HIGH / ACT_LOW  request polarity selectors for the ACT parameter
//   enc_width(n)        index width for an n-entry vector ($clog2(n), minimum 1)
// -----------------------------------------------------------------------------
package prio_enc_pkg;

  localparam logic ACT_HIGH = 1'b1;
  localparam logic ACT_LOW  = 1'b0;

  // A single-entry vector still needs one index bit to be representable.
  function automatic int enc_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : prio_enc_pkg

// File: rtl/prio_enc_core.sv
// -----------------------------------------------------------------------------
// prio_enc_core
//
// Purely combinational priority-encoder core. Reports whether any request bit
// is active and the index of the highest-numbered active bit.
//
// Parameters:
//   IN    width of the request vector (>= 2)
//   ACT   active level of a request bit (ACT_HIGH or ACT_LOW)
//   IDXW  width of the produced index
//
// Ports:
//   in      [IN-1:0]    request vector, bit i active when in[i] == ACT
//   hit                 at least one bit active
//   idx     [IDXW-1:0]  index of the highest active bit, 0 when hit = 0
//   onehot  [IN-1:0]    one-hot form of idx, all zero when hit = 0
//                       (only present when PRIO_ENC_ONEHOT_EN is defined)
//
// Optional feature macro: PRIO_ENC_ONEHOT_EN
// -----------------------------------------------------------------------------
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int   IN   = 16,
  parameter logic ACT  = ACT_HIGH,
  parameter int   IDXW = enc_width(IN)
) (
  input  logic [IN-1:0]   in,
  output logic            hit,
  output logic [IDXW-1:0] idx
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [IN-1:0]   onehot
`endif
);

  // The request vector is padded up to a power of two so the reduction can be
  // a complete binary tree with IDXW levels.
  localparam int LEVELS = IDXW;
  localparam int LEAVES = 1 << LEVELS;

  // Heap layout: node 1 is the root, node n has children 2n (lower half) and
  // 2n+1 (upper half), leaves occupy LEAVES .. 2*LEAVES-1.
  logic [2*LEAVES-1:1] hit_t;
  logic [IDXW-1:0]     idx_t [1:2*LEAVES-1];

  // Each node carries an index relative to its own subtree. At height l the
  // node prefers its upper child and prepends one index bit at position l-1,
  // so an empty subtree always reports relative index 0 and no final masking
  // is needed at the root.
  always_comb begin
    for (int n = 1; n < 2 * LEAVES; n++) begin
      hit_t[n] = 1'b0;
      idx_t[n] = '0;
    end

    for (int i = 0; i < IN; i++) begin
      hit_t[LEAVES + i] = (in[i] == ACT);
    end

    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < (LEAVES >> l); j++) begin
        hit_t[(LEAVES >> l) + j] = hit_t[2 * ((LEAVES >> l) + j)] |
                                   hit_t[2 * ((LEAVES >> l) + j) + 1];
        if (hit_t[2 * ((LEAVES >> l) + j) + 1]) begin
          idx_t[(LEAVES >> l) + j] = idx_t[2 * ((LEAVES >> l) + j) + 1] |
                                     (IDXW'(1) << (l - 1));
        end else begin
          idx_t[(LEAVES >> l) + j] = idx_t[2 * ((LEAVES >> l) + j)];
        end
      end
    end
  end

  assign hit = hit_t[1];
  assign idx = idx_t[1];

`ifdef PRIO_ENC_ONEHOT_EN
  always_comb begin
    onehot = '0;
    for (int i = 0; i < IN; i++) begin
      onehot[i] = hit_t[1] && (idx_t[1] == IDXW'(i));
    end
  end
`endif

endmodule : prio_enc_core

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
//
// Parameterised priority encoder with registered outputs. Reduces a request
// vector to the index of its highest-numbered active bit plus a valid flag,
// one cycle after capture.
//
// Parameters:
//   IN   width of the request vector (>= 2)
//   OUT  width of the encoded index (>= $clog2(IN))
//   ACT  active level of a request bit (1 = active-high, 0 = active-low)
//
// Ports:
//   clk     clock, rising-edge active
//   reset   asynchronous, active-high reset
//   en      capture enable; outputs hold while low
//   in      [IN-1:0]   request vector
//   valid   registered, high when any bit was active at capture (always
//           active-high regardless of ACT)
//   out     [OUT-1:0]  registered index of the highest active bit
//   out_oh  [IN-1:0]   registered one-hot form of out, zero when not valid
//                      (only present when PRIO_ENC_ONEHOT_EN is defined)
//
// Optional feature macro: PRIO_ENC_ONEHOT_EN
// -----------------------------------------------------------------------------
module prio_enc
  import prio_enc_pkg::*;
#(
  parameter int   IN  = 16,
  parameter int   OUT = $clog2(IN),
  parameter logic ACT = ACT_HIGH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [IN-1:0]  in,
  output logic           valid,
  output logic [OUT-1:0] out
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [IN-1:0]  out_oh
`endif
);

  localparam int IDXW = enc_width(IN);

  logic            core_hit;
  logic [IDXW-1:0] core_idx;
  logic [OUT-1:0]  core_idx_ext;

`ifdef PRIO_ENC_ONEHOT_EN
  logic [IN-1:0]   core_onehot;
`endif

  prio_enc_core #(
    .IN   (IN),
    .ACT  (ACT),
    .IDXW (IDXW)
  ) u_core (
    .in     (in),
    .hit    (core_hit),
    .idx    (core_idx)
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .onehot (core_onehot)
`endif
  );

  // OUT may be wider than the natural index width; upper bits are zero.
  assign core_idx_ext = OUT'(core_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      out   <= '0;
    end else if (en) begin
      valid <= core_hit;
      out   <= core_idx_ext;
    end
  end

`ifdef PRIO_ENC_ONEHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_oh <= '0;
    end else if (en) begin
      out_oh <= core_onehot;
    end
  end
`endif

endmodule : prio_enc

// File: tb/tb_prio_enc.sv
// -----------------------------------------------------------------------------
// tb_prio_enc
//
// Self-checking bench for prio_enc. Two instances are driven together: an
// active-high one with the stimulus vector and an active-low one with its
// complement, so both see the same set of active requests and share one
// expected response. Expected responses are queued when stimulus is applied
// and compared by an independent monitor one clock edge later.
// -----------------------------------------------------------------------------
module tb_prio_enc;
  import prio_enc_pkg::*;

  localparam int IN  = 16;
  localparam int OUT = 4;

  typedef struct packed {
    logic           valid;
    logic [OUT-1:0] out;
    logic [IN-1:0]  oh;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           en;
  logic [IN-1:0]  in_vec;
  logic [IN-1:0]  in_low;

  logic           valid_hi;
  logic [OUT-1:0] out_hi;
  logic           valid_lo;
  logic [OUT-1:0] out_lo;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [IN-1:0]  oh_hi;
  logic [IN-1:0]  oh_lo;
`endif

  exp_t exp_q[$];
  exp_t model_state;
  int   checks;
  int   failures;

  assign in_low = ~in_vec;

  prio_enc #(.IN(IN), .OUT(OUT), .ACT(ACT_HIGH)) dut_hi (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .in     (in_vec),
    .valid  (valid_hi),
    .out    (out_hi)
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .out_oh (oh_hi)
`endif
  );

  prio_enc #(.IN(IN), .OUT(OUT), .ACT(ACT_LOW)) dut_lo (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .in     (in_low),
    .valid  (valid_lo),
    .out    (out_lo)
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .out_oh (oh_lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan upward and remember the last active bit seen, which is
  // the highest one.
  function automatic exp_t refModel(input logic [IN-1:0] vec);
    exp_t r;
    r = '0;
    for (int i = 0; i < IN; i++) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.out   = OUT'(i);
        r.oh    = IN'(1) << i;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input exp_t e);
    checkOutput({name, ".hi.valid"}, 32'(valid_hi), 32'(e.valid));
    checkOutput({name, ".hi.out"},   32'(out_hi),   32'(e.out));
    checkOutput({name, ".lo.valid"}, 32'(valid_lo), 32'(e.valid));
    checkOutput({name, ".lo.out"},   32'(out_lo),   32'(e.out));
`ifdef PRIO_ENC_ONEHOT_EN
    checkOutput({name, ".hi.oh"},    32'(oh_hi),    32'(e.oh));
    checkOutput({name, ".lo.oh"},    32'(oh_lo),    32'(e.oh));
`endif
  endtask

  // Registers capture only when enabled; otherwise the last result is held.
  task automatic modelStep(input logic [IN-1:0] vec, input logic e);
    if (e) model_state = refModel(vec);
    exp_q.push_back(model_state);
  endtask

  task automatic applyStimulus(input logic [IN-1:0] vec, input logic e);
    @(negedge clk);
    in_vec = vec;
    en     = e;
    modelStep(vec, e);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset       = 1'b0;
    model_state = '0;
    modelStep(in_vec, en);
  endtask

  // Monitor: the outputs are updated every edge, so one queued expectation is
  // consumed shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkAll("scoreboard", e);
      end
    end
  end

  initial begin
    logic [IN-1:0] rvec;
    logic          ren;

    checks      = 0;
    failures    = 0;
    model_state = '0;
    reset       = 1'b0;
    en          = 1'b0;
    in_vec      = '0;

    #1 reset = 1'b1;
    #1 checkAll("reset_init", '0);

    in_vec = 16'hFFFF;
    en     = 1'b1;
    @(posedge clk);
    #1 checkAll("reset_dominates_en", '0);

    releaseReset();

    for (int k = 0; k < IN; k++) applyStimulus(IN'(1) << k, 1'b1);
    applyStimulus(16'h0000, 1'b1);

    applyStimulus(16'h0101, 1'b1);
    applyStimulus(16'hFFFF, 1'b1);
    applyStimulus(16'h0001, 1'b1);

    applyStimulus(16'h0010, 1'b1);
    applyStimulus(16'h0400, 1'b0);
    applyStimulus(16'h8000, 1'b0);
    applyStimulus(16'h0400, 1'b0);
    applyStimulus(16'h0400, 1'b1);

    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(0, 2))
        0:       rvec = IN'($urandom);
        1:       rvec = IN'($urandom & $urandom & $urandom);
        default: rvec = IN'($urandom) >> $urandom_range(0, IN - 1);
      endcase
      ren = ($urandom_range(0, 3) != 0);
      applyStimulus(rvec, ren);
    end

    // Asynchronous reset between edges, with the top request bit active.
    applyStimulus(16'h8000, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkAll("reset_async", '0);
    @(posedge clk);
    #1 checkAll("reset_hold", '0);
    releaseReset();

    for (int v = 1; v < (1 << IN); v++) applyStimulus(IN'(v), 1'b1);

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prio_enc

// File: doc/prio_enc.md
Name: prio_enc

Overview:
- Parameterised priority encoder with registered outputs.
- Scans an IN-bit request vector and reports the index of the highest-numbered active bit, plus a valid flag.
- Request polarity is selectable by parameter.
- Used wherever a request vector must be reduced to one index, e.g. free-entry search or arbitration.

Parameters:
- IN, 16, width of request vector; IN >= 2.
- OUT, $clog2(IN), width of encoded index; must be >= $clog2(IN).
- ACT, 1'b1, active level of a request bit: 1 = active-high, 0 = active-low.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0, output registers hold.
- in  input  IN  request vector; bit i is active when in[i] == ACT.
- valid  output  1  registered; 1 when at least one bit was active at capture. Always active-high, regardless of ACT.
- out  output  OUT  registered index of the highest active bit.

Behaviour:
- Combinational stage:
  - act[i] = (in[i] == ACT).
  - hit = |act.
  - idx = largest i with act[i] = 1, zero-extended to OUT bits; idx = 0 when hit = 0.
- Priority: highest index wins. Lower active bits are ignored.
- Register stage: on rising clk with en = 1, valid <= hit and out <= idx. With en = 0, both hold.
- Latency: exactly 1 cycle from in to valid/out. No handshake, no backpressure.
- Reset (asynchronous assert, released synchronously by the system):
  - valid = 0, out = 0, immediately on assertion.
  - Reset dominates en.
  - First capture is on the first rising edge after deassertion.
- Boundaries:
  - No active bit: valid = 0, out = 0.
  - All bits active: out = IN-1.
  - Only bit 0 active: valid = 1, out = 0. Distinguished from "none active" only by valid.
  - Non-power-of-two IN: upper index codes never produced.
- ACT = 0: in = all ones means no request. in = ~(1<<k) gives out = k, valid = 1.
- X on in propagates; no X-masking required.

Optional Feature:
- Macro: PRIO_ENC_ONEHOT_EN.
- Defined:
  - Adds output port out_oh [IN-1:0], registered alongside out.
  - out_oh has exactly one bit set, at position idx, when hit = 1; it is all zero when hit = 0.
  - out_oh resets to 0 and holds when en = 0.
- Undefined: port absent; logic identical otherwise.

Decomposition:
- Package prio_enc_pkg:
  - ACT_HIGH = 1'b1 and ACT_LOW = 1'b0 constants.
  - Function enc_width(n) returning $clog2(n) with minimum 1.
- Sub-module prio_enc_core:
  - Purely combinational: produces hit, idx and, optionally, the one-hot vector.
  - Implemented as a log-depth binary tree (upper half preferred at each node) for timing.
  - prio_enc adds only the enable/reset registers.

Test Plan:
- Reset: assert reset mid-run with in = 16'h8000 -> valid = 0, out = 0 immediately, without waiting for a clock; after release, next edge gives valid = 1, out = 15.
- One-hot walk, ACT = 1, IN = 16: in = 1<<k for k = 0..15 -> one cycle later valid = 1, out = k. in = 0 -> valid = 0, out = 0.
- Active-low walk, ACT = 0: in = 16'hFFFF -> valid = 0, out = 0. in = 16'hFFFF ^ (1<<k) -> valid = 1, out = k.
- Priority: in = 16'h0101 -> out = 8. in = 16'hFFFF -> out = 15. in = 16'h0001 -> out = 0, valid = 1.
- Exhaustive: count in from 1 to 2^16-1, one value per cycle. Compare the delayed output to a reference model (highest set index) -> zero mismatches.
- Enable hold: capture in = 16'h0010 (out = 4), drop en, apply in = 16'h0400 -> out stays 4. Raise en -> out = 10 next cycle. With PRIO_ENC_ONEHOT_EN defined, out_oh = 16'h0400.
